// File: rtl/square_wave_meas_ctrl_pkg.sv
// rtl/square_wave_meas_ctrl_pkg.sv - shared types and constants for the square-wave measurement sequencer
package square_wave_meas_ctrl_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_SAT     = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_ARM    = 3'd2,
        ST_GATE   = 3'd3,
        ST_CLOSE  = 3'd4,
        ST_DONE   = 3'd5
    } meas_state_t;

    // Round-robin pick: first enabled channel after the one served last.
    function automatic logic next_ch(input logic [1:0] en, input logic last);
        if (last) begin
            return en[0] ? 1'b0 : 1'b1;
        end
        return en[1] ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/square_wave_meas_ctrl_edge_sync.sv
// rtl/square_wave_meas_ctrl_edge_sync.sv - 2-FF synchronizer with delayed sample and rising-edge pulse
module square_wave_meas_ctrl_edge_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_wave,
    output logic o_level,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_sd;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_sd <= 1'b0;
        end else begin
            r_s1 <= i_wave;
            r_s2 <= r_s1;
            r_sd <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_sd;

endmodule

// File: rtl/square_wave_meas_ctrl.sv
// rtl/square_wave_meas_ctrl.sv - two-channel equal-precision frequency/duty measurement sequencer
module square_wave_meas_ctrl
    import square_wave_meas_ctrl_pkg::*;
#(
    parameter int SYS_CLK_FREQ   = 50_000_000,
    parameter int CNT_W          = CNT_W_DEF,
    parameter int TIMEOUT_CYCLES = SYS_CLK_FREQ
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [1:0]       wave_in,
    input  logic [1:0]       ch_en,
    input  logic [CNT_W-1:0] gate_cycles,
    input  logic             start,
    input  logic             cont,
    output logic             busy,
    output logic             done,
    output logic             result_ch,
    output logic [CNT_W-1:0] result_edges,
    output logic [CNT_W-1:0] result_ref,
    output logic [CNT_W-1:0] result_high,
    output logic [1:0]       result_err
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       w_level;
    logic [1:0]       w_rise_ch;
    logic             w_rise;
    logic             w_lvl;
    logic             w_next;
    logic [CNT_W-1:0] w_ref_nx;
    logic [CNT_W-1:0] w_edge_nx;
    logic [CNT_W-1:0] w_high_nx;
    logic             w_sat;
    logic [CNT_W-1:0] w_gate_init;

    meas_state_t      r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_sel;
    logic             r_last;
    logic [CNT_W-1:0] r_tmo;
    logic [CNT_W-1:0] r_gate_tmr;
    logic [CNT_W-1:0] r_ref;
    logic [CNT_W-1:0] r_edge;
    logic [CNT_W-1:0] r_high;
    logic             r_res_ch;
    logic [CNT_W-1:0] r_res_edges;
    logic [CNT_W-1:0] r_res_ref;
    logic [CNT_W-1:0] r_res_high;
    logic [1:0]       r_res_err;

    for (genvar g = 0; g < 2; g++) begin : g_sync
        square_wave_meas_ctrl_edge_sync u_sync (
            .i_clk   (sys_clk),
            .i_rst_n (sys_rst_n),
            .i_wave  (wave_in[g]),
            .o_level (w_level[g]),
            .o_rise  (w_rise_ch[g])
        );
    end

    assign w_rise = r_sel ? w_rise_ch[1] : w_rise_ch[0];
    assign w_lvl  = r_sel ? w_level[1]   : w_level[0];
    assign w_next = next_ch(ch_en, r_last);

    // Counters stick at all-ones instead of wrapping.
    assign w_ref_nx  = (&r_ref) ? r_ref : r_ref + 1'b1;
    assign w_edge_nx = (w_rise && !(&r_edge)) ? r_edge + 1'b1 : r_edge;
    assign w_high_nx = (w_lvl && !(&r_high)) ? r_high + 1'b1 : r_high;
    assign w_sat     = (&w_ref_nx) | (&w_edge_nx) | (&w_high_nx);

    assign w_gate_init = (gate_cycles == '0) ? CNT_W'(1) : gate_cycles;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sel       <= 1'b0;
            r_last      <= 1'b1;
            r_tmo       <= '0;
            r_gate_tmr  <= '0;
            r_ref       <= '0;
            r_edge      <= '0;
            r_high      <= '0;
            r_res_ch    <= 1'b0;
            r_res_edges <= '0;
            r_res_ref   <= '0;
            r_res_high  <= '0;
            r_res_err   <= 2'b00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && ch_en != 2'b00) begin
                        r_state <= ST_SELECT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SELECT: begin
                    if (ch_en == 2'b00) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_sel   <= w_next;
                        r_last  <= w_next;
                        r_tmo   <= '0;
                        r_state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (w_rise) begin
                        r_ref      <= '0;
                        r_edge     <= '0;
                        r_high     <= '0;
                        r_gate_tmr <= w_gate_init;
                        r_state    <= ST_GATE;
                    end else if (r_tmo == TMO_LAST) begin
                        r_res_ch    <= r_sel;
                        r_res_edges <= '0;
                        r_res_ref   <= '0;
                        r_res_high  <= '0;
                        r_res_err   <= 2'b01;
                        r_done      <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_GATE: begin
                    r_ref      <= w_ref_nx;
                    r_edge     <= w_edge_nx;
                    r_high     <= w_high_nx;
                    r_gate_tmr <= r_gate_tmr - 1'b1;
                    // Last gate clock: a rise here closes on the spot, otherwise wait for one.
                    if (r_gate_tmr == CNT_W'(1)) begin
                        if (w_rise) begin
                            r_res_ch                 <= r_sel;
                            r_res_edges              <= w_edge_nx;
                            r_res_ref                <= w_ref_nx;
                            r_res_high               <= w_high_nx;
                            r_res_err[ERR_SAT]       <= w_sat;
                            r_res_err[ERR_TIMEOUT]   <= 1'b0;
                            r_done                   <= 1'b1;
                            r_state                  <= ST_DONE;
                        end else begin
                            r_tmo   <= '0;
                            r_state <= ST_CLOSE;
                        end
                    end
                end
                ST_CLOSE: begin
                    r_ref  <= w_ref_nx;
                    r_edge <= w_edge_nx;
                    r_high <= w_high_nx;
                    if (w_rise || r_tmo == TMO_LAST) begin
                        r_res_ch               <= r_sel;
                        r_res_edges            <= w_edge_nx;
                        r_res_ref              <= w_ref_nx;
                        r_res_high             <= w_high_nx;
                        r_res_err[ERR_SAT]     <= w_sat;
                        r_res_err[ERR_TIMEOUT] <= ~w_rise;
                        r_done                 <= 1'b1;
                        r_state                <= ST_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (cont) begin
                        r_state <= ST_SELECT;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign result_ch    = r_res_ch;
    assign result_edges = r_res_edges;
    assign result_ref   = r_res_ref;
    assign result_high  = r_res_high;
    assign result_err   = r_res_err;

endmodule

// File: tb/tb_square_wave_meas_ctrl.sv
// tb/tb_square_wave_meas_ctrl.sv - directed self-checking bench for square_wave_meas_ctrl
module tb_square_wave_meas_ctrl;

    localparam int CNT_W = 32;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic [1:0]       wave_in;
    logic [1:0]       ch_en;
    logic [CNT_W-1:0] gate_cycles;
    logic             start;
    logic             cont;
    logic             busy;
    logic             done;
    logic             result_ch;
    logic [CNT_W-1:0] result_edges;
    logic [CNT_W-1:0] result_ref;
    logic [CNT_W-1:0] result_high;
    logic [1:0]       result_err;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int snap     = 0;
    int p0 = 0, h0 = 0, p1 = 0, h1 = 0;
    int ph0 = 0, ph1 = 0;

    square_wave_meas_ctrl #(
        .SYS_CLK_FREQ   (50_000_000),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .wave_in      (wave_in),
        .ch_en        (ch_en),
        .gate_cycles  (gate_cycles),
        .start        (start),
        .cont         (cont),
        .busy         (busy),
        .done         (done),
        .result_ch    (result_ch),
        .result_edges (result_edges),
        .result_ref   (result_ref),
        .result_high  (result_high),
        .result_err   (result_err)
    );

    always #10 sys_clk = ~sys_clk;

    // Free-running square waves: period p, high h clocks; p == 0 holds the pin low.
    always @(negedge sys_clk) begin
        if (p0 == 0) begin
            wave_in[0] = 1'b0;
            ph0 = 0;
        end else begin
            wave_in[0] = (ph0 < h0);
            ph0 = (ph0 + 1) % p0;
        end
        if (p1 == 0) begin
            wave_in[1] = 1'b0;
            ph1 = 0;
        end else begin
            wave_in[1] = (ph1 < h1);
            ph1 = (ph1 + 1) % p1;
        end
    end

    always @(posedge sys_clk) begin
        #1;
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(input int max_cyc);
        do begin
            @(negedge sys_clk);
            cyc++;
        end while (done !== 1'b1 && cyc < max_cyc);
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic check_res(input string tag, input logic ch, input int e, input int r,
                             input int h, input logic [1:0] err);
        check({tag, "_ch"},    {63'd0, result_ch}, {63'd0, ch});
        check({tag, "_edges"}, {32'd0, result_edges}, 64'(e));
        check({tag, "_ref"},   {32'd0, result_ref},   64'(r));
        check({tag, "_high"},  {32'd0, result_high},  64'(h));
        check({tag, "_err"},   {62'd0, result_err},   {62'd0, err});
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
    endtask

    initial begin
        sys_rst_n   = 1'b0;
        start       = 1'b0;
        cont        = 1'b0;
        ch_en       = 2'b00;
        gate_cycles = 32'd1000;
        wave_in     = 2'b00;

        repeat (3) @(negedge sys_clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check_res("rst", 1'b0, 0, 0, 0, 2'b00);
        sys_rst_n = 1'b1;

        // 1 MHz 50 % on ch0, gate 1000: 20 whole periods land exactly on expiry.
        p0 = 50; h0 = 25;
        ch_en = 2'b01;
        repeat (20) @(negedge sys_clk);
        pulse_start();
        check("t1_busy_on", {63'd0, busy}, 64'd1);
        wait_done(3000);
        check_res("t1", 1'b0, 20, 1000, 500, 2'b00);
        check("t1_busy_at_done", {63'd0, busy}, 64'd1);
        @(negedge sys_clk);
        check("t1_done_pulse", {63'd0, done}, 64'd0);
        check("t1_busy_off", {63'd0, busy}, 64'd0);

        // Continuous round-robin; reset first so ch0 is served first again.
        do_reset();
        p1 = 125; h1 = 31;
        ch_en = 2'b11;
        cont = 1'b1;
        repeat (10) @(negedge sys_clk);
        pulse_start();
        wait_done(3000);
        check_res("t2a", 1'b0, 20, 1000, 500, 2'b00);
        cyc = 0;
        wait_done(3000);
        check_res("t2b", 1'b1, 8, 1000, 248, 2'b00);
        cyc = 0;
        wait_done(3000);
        check_res("t2c", 1'b0, 20, 1000, 500, 2'b00);
        cont = 1'b0;
        snap = done_cnt;
        @(negedge sys_clk);
        check("t2_busy_off", {63'd0, busy}, 64'd0);
        repeat (1500) @(negedge sys_clk);
        check("t2_no_extra_done", 64'(done_cnt), 64'(snap));

        // Stuck-low ch0: start edge, one SELECT clock, then 1000 ARM clocks before DONE.
        p0 = 0; p1 = 0;
        ch_en = 2'b01;
        repeat (10) @(negedge sys_clk);
        pulse_start();
        wait_done(3000);
        check("t3_latency", 64'(cyc), 64'd1002);
        check_res("t3", 1'b0, 0, 0, 0, 2'b01);

        // Gate expiry between edges: closing waits for the next rise.
        p0 = 300; h0 = 100;
        gate_cycles = 32'd1000;
        repeat (10) @(negedge sys_clk);
        pulse_start();
        wait_done(4000);
        check_res("t4a", 1'b0, 4, 1200, 400, 2'b00);
        gate_cycles = 32'd0;
        repeat (5) @(negedge sys_clk);
        pulse_start();
        wait_done(4000);
        check_res("t4b", 1'b0, 1, 300, 100, 2'b00);

        // start held through busy yields a single measurement.
        p0 = 50; h0 = 25;
        gate_cycles = 32'd1000;
        repeat (10) @(negedge sys_clk);
        snap = done_cnt;
        @(negedge sys_clk);
        start = 1'b1;
        repeat (200) @(negedge sys_clk);
        start = 1'b0;
        repeat (1500) @(negedge sys_clk);
        check("t5_one_done", 64'(done_cnt), 64'(snap + 1));
        check("t5_busy_off", {63'd0, busy}, 64'd0);
        check_res("t5", 1'b0, 20, 1000, 500, 2'b00);
        ch_en = 2'b00;
        pulse_start();
        repeat (10) @(negedge sys_clk);
        check("t5_en0_busy", {63'd0, busy}, 64'd0);
        ch_en = 2'b01;
        pulse_start();
        check("t5_sel_busy", {63'd0, busy}, 64'd1);
        ch_en = 2'b00;
        repeat (5) @(negedge sys_clk);
        check("t5_sel_abort_busy", {63'd0, busy}, 64'd0);
        repeat (1200) @(negedge sys_clk);
        check("t5_no_done", 64'(done_cnt), 64'(snap + 1));

        // Reset in the middle of a gate.
        ch_en = 2'b01;
        pulse_start();
        repeat (200) @(negedge sys_clk);
        snap = done_cnt;
        sys_rst_n = 1'b0;
        #1;
        check("t6_busy", {63'd0, busy}, 64'd0);
        check("t6_done", {63'd0, done}, 64'd0);
        check_res("t6_rst", 1'b0, 0, 0, 0, 2'b00);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (1200) @(negedge sys_clk);
        check("t6_no_done", 64'(done_cnt), 64'(snap));
        pulse_start();
        wait_done(3000);
        check_res("t6_after", 1'b0, 20, 1000, 500, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
